// File: rtl/accel_pkg.sv
// Shared constants and FSM encoding for the accelerometer BCD scheduler.
package accel_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int AXES           = 3;

    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Y = 2'd1;
    localparam logic [1:0] AX_Z = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_PUBLISH
    } sched_state_t;

endpackage

// File: rtl/bcd_shift_core.sv
// Iterative double-dabble converter: one add-3/shift step per clock, DATA_W steps per run.
module bcd_shift_core #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    // Two spare digits keep intermediate add-3 results from overflowing.
    localparam int BCD_INT_W = 4 * (DIGITS + 2);
    localparam int CNT_W     = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]    bin_sr;
    logic [BCD_INT_W-1:0] bcd_sr;
    logic [BCD_INT_W-1:0] bcd_adj;
    logic [CNT_W-1:0]     cnt;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS + 2; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
        end else if (start) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            cnt    <= CNT_W'(DATA_W);
        end else if (cnt != '0) begin
            bcd_sr <= (bcd_adj << 1) | BCD_INT_W'(bin_sr[DATA_W-1]);
            bin_sr <= bin_sr << 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    // High during the last step, so the FSM leaves SHIFT as the final shift lands.
    assign done = (cnt == CNT_W'(1));
    assign bcd  = bcd_sr[4*DIGITS-1:0];

endmodule

// File: rtl/accel_bcd_scheduler.sv
// Snapshots X/Y/Z, converts them one after another through a shared BCD core,
// and publishes sign/saturation/digits for all three axes on a single edge.
module accel_bcd_scheduler
    import accel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 data_update,
    input  logic [DATA_W-1:0]    data_x,
    input  logic [DATA_W-1:0]    data_y,
    input  logic [DATA_W-1:0]    data_z,
    input  logic                 freeze,
    input  logic                 ovr_clr,
    output logic [4*DIGITS-1:0]  bcd_x,
    output logic [4*DIGITS-1:0]  bcd_y,
    output logic [4*DIGITS-1:0]  bcd_z,
    output logic [2:0]           sign,
    output logic [2:0]           sat,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int                BCD_W     = 4 * DIGITS;
    localparam int                MAG_W     = DATA_W + 1;
    localparam logic [MAG_W-1:0]  MAX_VAL   = MAG_W'(10 ** DIGITS - 1);
    localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};

    sched_state_t state, state_nxt;

    logic [1:0]        axis;
    logic [DATA_W-1:0] snap    [AXES];
    logic [BCD_W-1:0]  res_bcd [AXES];
    logic [AXES-1:0]   res_sign;
    logic [AXES-1:0]   res_sat;
    logic              cur_sign;
    logic              cur_sat;

    logic [DATA_W-1:0] cur_sample;
    logic [MAG_W-1:0]  cur_ext;
    logic [MAG_W-1:0]  cur_mag;
    logic              load_sat;
    logic              core_start;
    logic              core_done;
    logic [BCD_W-1:0]  core_bcd;
    logic              drop;

    // One extra bit so the most negative sample still has a representable magnitude.
    assign cur_sample = snap[axis];
    assign cur_ext    = {cur_sample[DATA_W-1], cur_sample};
    assign cur_mag    = cur_sample[DATA_W-1] ? (~cur_ext + MAG_W'(1)) : cur_ext;
    assign load_sat   = (cur_mag > MAX_VAL);

    assign busy = (state != ST_IDLE);
    assign drop = data_update && (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        case (state)
            ST_IDLE:    if (data_update && !freeze) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (load_sat) begin
                    state_nxt = ST_STORE;
                end else begin
                    core_start = 1'b1;
                    state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT:   if (core_done) state_nxt = ST_STORE;
            ST_STORE:   state_nxt = (axis == AX_Z) ? ST_PUBLISH : ST_LOAD;
            ST_PUBLISH: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            axis         <= AX_X;
            cur_sign     <= 1'b0;
            cur_sat      <= 1'b0;
            res_sign     <= '0;
            res_sat      <= '0;
            bcd_x        <= '0;
            bcd_y        <= '0;
            bcd_z        <= '0;
            sign         <= '0;
            sat          <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < AXES; i++) begin
                snap[i]    <= '0;
                res_bcd[i] <= '0;
            end
        end else begin
            result_valid <= (state == ST_PUBLISH);

            // Latch on the edge that accepts data_update, while the sample is still valid.
            if (state == ST_IDLE && data_update && !freeze) begin
                snap[AX_X] <= data_x;
                snap[AX_Y] <= data_y;
                snap[AX_Z] <= data_z;
            end

            if (state == ST_CAPTURE) begin
                axis <= AX_X;
            end

            if (state == ST_LOAD) begin
                cur_sign <= cur_sample[DATA_W-1];
                cur_sat  <= load_sat;
            end

            if (state == ST_STORE) begin
                res_bcd[axis]  <= cur_sat ? ALL_NINES : core_bcd;
                res_sign[axis] <= cur_sign;
                res_sat[axis]  <= cur_sat;
                if (axis != AX_Z) begin
                    axis <= axis + 2'd1;
                end
            end

            if (state == ST_PUBLISH) begin
                bcd_x <= res_bcd[AX_X];
                bcd_y <= res_bcd[AX_Y];
                bcd_z <= res_bcd[AX_Z];
                sign  <= res_sign;
                sat   <= res_sat;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    bcd_shift_core #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (core_start),
        .bin     (cur_mag[DATA_W-1:0]),
        .done    (core_done),
        .bcd     (core_bcd)
    );

endmodule

// File: tb/tb_accel_bcd_scheduler.sv
// Directed bench for accel_bcd_scheduler: conversions, saturation, overrun, freeze, reset.
module tb_accel_bcd_scheduler;

    localparam int DATA_W = 16;
    localparam int DIGITS = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                data_update;
    logic [DATA_W-1:0]   data_x, data_y, data_z;
    logic                freeze;
    logic                ovr_clr;
    logic [4*DIGITS-1:0] bcd_x, bcd_y, bcd_z;
    logic [2:0]          sign, sat;
    logic                result_valid, busy, overrun;

    int checks   = 0;
    int failures = 0;
    int lat;
    int seen_rv;
    int seen_busy;

    always #5 clk = ~clk;

    accel_bcd_scheduler #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_update  (data_update),
        .data_x       (data_x),
        .data_y       (data_y),
        .data_z       (data_z),
        .freeze       (freeze),
        .ovr_clr      (ovr_clr),
        .bcd_x        (bcd_x),
        .bcd_y        (bcd_y),
        .bcd_z        (bcd_z),
        .sign         (sign),
        .sat          (sat),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_update(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                input logic [DATA_W-1:0] z);
        data_x      = x;
        data_y      = y;
        data_z      = z;
        data_update = 1'b1;
        tick();
        data_update = 1'b0;
    endtask

    // Counts edges after the accepting edge until result_valid rises; bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_result(input string tag, input logic [11:0] ex, input logic [11:0] ey,
                              input logic [11:0] ez, input logic [2:0] esg, input logic [2:0] est);
        chk({tag, "_bcd_x"}, 32'(bcd_x), 32'(ex));
        chk({tag, "_bcd_y"}, 32'(bcd_y), 32'(ey));
        chk({tag, "_bcd_z"}, 32'(bcd_z), 32'(ez));
        chk({tag, "_sign"},  32'(sign),  32'(esg));
        chk({tag, "_sat"},   32'(sat),   32'(est));
    endtask

    initial begin
        reset_n     = 1'b0;
        data_update = 1'b0;
        data_x      = '0;
        data_y      = '0;
        data_z      = '0;
        freeze      = 1'b0;
        ovr_clr     = 1'b0;
        tick();
        tick();
        chk_result("reset", 12'h000, 12'h000, 12'h000, 3'b000, 3'b000);
        chk("reset_rv",      32'(result_valid), 32'd0);
        chk("reset_busy",    32'(busy),         32'd0);
        chk("reset_overrun", 32'(overrun),      32'd0);
        reset_n = 1'b1;
        tick();

        // Basic conversion, mixed signs and zero
        pulse_update(16'd123, 16'hFFD3, 16'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_result(lat);
        chk("t1_latency", 32'(lat), 32'd56);
        chk_result("t1", 12'h123, 12'h045, 12'h000, 3'b010, 3'b000);
        tick();
        chk("t1_rv_pulse", 32'(result_valid), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Saturation, including the most negative sample, and the 999 boundary
        pulse_update(16'd1000, 16'h8000, 16'd999);
        wait_result(lat);
        chk("t2_latency", 32'(lat), 32'd24);
        chk_result("t2", 12'h999, 12'h999, 12'h999, 3'b010, 3'b011);
        tick();

        // Overrun: a second update 10 cycles in is dropped
        pulse_update(16'd7, 16'd250, 16'hFF9C);
        repeat (9) tick();
        pulse_update(16'd1, 16'd2, 16'd3);
        chk("t3_overrun_set", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t3_overrun_clr", 32'(overrun), 32'd0);
        ovr_clr     = 1'b1;
        data_update = 1'b1;
        tick();
        ovr_clr     = 1'b0;
        data_update = 1'b0;
        chk("t3_set_wins", 32'(overrun), 32'd1);
        wait_result(lat);
        chk("t3_latency", 32'(lat + 12), 32'd56);
        chk_result("t3", 12'h007, 12'h250, 12'h100, 3'b100, 3'b000);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t3_overrun_final", 32'(overrun), 32'd0);

        // Freeze in IDLE: update ignored entirely
        freeze    = 1'b1;
        seen_rv   = 0;
        seen_busy = 0;
        pulse_update(16'd1, 16'd1, 16'd1);
        for (int i = 0; i < 70; i++) begin
            if (busy === 1'b1) seen_busy++;
            if (result_valid === 1'b1) seen_rv++;
            tick();
        end
        chk("t4_no_busy", 32'(seen_busy), 32'd0);
        chk("t4_no_rv",   32'(seen_rv),   32'd0);
        chk("t4_overrun", 32'(overrun),   32'd0);
        chk_result("t4", 12'h007, 12'h250, 12'h100, 3'b100, 3'b000);
        freeze = 1'b0;

        // Freeze rising mid-conversion does not stop the snapshot
        pulse_update(16'd999, 16'd1, 16'hFC19);
        repeat (5) tick();
        freeze = 1'b1;
        wait_result(lat);
        chk("t5_latency", 32'(lat + 5), 32'd56);
        chk_result("t5", 12'h999, 12'h001, 12'h999, 3'b100, 3'b000);
        freeze = 1'b0;
        tick();

        // Async reset at cycle 30 of a conversion
        pulse_update(16'd5, 16'd5, 16'd5);
        repeat (29) tick();
        reset_n = 1'b0;
        #1;
        chk_result("t6_rst", 12'h000, 12'h000, 12'h000, 3'b000, 3'b000);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        seen_rv = 0;
        for (int i = 0; i < 70; i++) begin
            if (result_valid === 1'b1) seen_rv++;
            tick();
        end
        chk("t6_no_rv", 32'(seen_rv), 32'd0);
        pulse_update(16'd42, 16'hFFFF, 16'd600);
        wait_result(lat);
        chk("t6_latency", 32'(lat), 32'd56);
        chk_result("t6", 12'h042, 12'h001, 12'h600, 3'b010, 3'b000);

        // Back-to-back snapshots issued right after each result_valid
        for (int i = 0; i < 3; i++) begin
            pulse_update(16'(100 + i), 16'd0, 16'd1000);
            chk($sformatf("t7_rv_low_%0d", i), 32'(result_valid), 32'd0);
            wait_result(lat);
            chk($sformatf("t7_latency_%0d", i), 32'(lat), 32'd40);
            chk_result($sformatf("t7_%0d", i), 12'(12'h100 + i), 12'h000, 12'h999, 3'b000, 3'b100);
        end
        chk("t7_overrun", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
